reg_load_sequencer: RTL and testbench



---
 rtl/reg_load_sequencer_pkg.sv | 9 +
 rtl/reg_load_sequencer_if.sv | 27 ++
 rtl/reg_load_sequencer_sat_counter.sv | 14 +
 rtl/reg_load_sequencer.sv | 62 ++++++
 tb/tb_reg_load_sequencer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/reg_load_sequencer_pkg.sv
// cpu_pkg: shared sequencer state type, opcode constants and decode helper
package cpu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_HALT} seq_state_t;
  localparam logic [31:0] OP_NOP = '0;
  localparam logic [31:0] OP_HALT = '1;
  function automatic logic is_load_op(input int unsigned opcode, input int unsigned num_regs);
    return opcode >= 1 && opcode <= num_regs;
  endfunction
endpackage

// File: rtl/reg_load_sequencer_if.sv
// reg_load_sequencer_if: instruction handshake, load bus and status between fetch and sequencer
interface reg_load_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int NUM_REGS = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W = 8
);
  logic instr_valid;
  logic instr_ready;
  logic [OPCODE_W-1:0] instr_opcode;
  logic [DATA_W-1:0] instr_operand;
  logic resume;
  logic [NUM_REGS-1:0] load_en;
  logic [DATA_W-1:0] load_data;
  logic illegal_op;
  logic halted;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] illegal_cnt;
  modport master (
    output instr_valid, instr_opcode, instr_operand, resume,
    input instr_ready, load_en, load_data, illegal_op, halted, retired_cnt, illegal_cnt
  );
  modport slave (
    input instr_valid, instr_opcode, instr_operand, resume,
    output instr_ready, load_en, load_data, illegal_op, halted, retired_cnt, illegal_cnt
  );
endinterface

// File: rtl/reg_load_sequencer_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic [W-1:0] count
);
  // count up on inc until saturated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/reg_load_sequencer.sv
// reg_load_sequencer: handshaked opcode decoder driving one-hot register loads, with NOP/HALT/illegal handling
module reg_load_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int NUM_REGS = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  reg_load_sequencer_if.slave bus
);
  if (NUM_REGS < 1 || NUM_REGS > 2**OPCODE_W - 2) begin : g_bad_cfg
    $error("reg_load_sequencer: NUM_REGS must be in 1..2**OPCODE_W-2");
  end
  seq_state_t state;
  logic [OPCODE_W-1:0] op_q;
  logic [DATA_W-1:0] opnd_q;
  logic in_dec, is_ld, is_nop, is_halt, take, ret_inc, ill_inc;
  // decode of the latched opcode and counter strobes
  always_comb begin
    in_dec = state == S_DECODE;
    take = state == S_IDLE && bus.instr_valid;
    is_ld = is_load_op(32'(op_q), NUM_REGS);
    is_nop = op_q == OPCODE_W'(OP_NOP);
    is_halt = op_q == OPCODE_W'(OP_HALT);
    ret_inc = (in_dec && is_nop) || state == S_EXEC;
    ill_inc = in_dec && !is_ld && !is_nop && !is_halt;
  end
  assign bus.instr_ready = state == S_IDLE;
  assign bus.halted = state == S_HALT;
  // state sequencing; resume only matters once HALT is the current state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state == S_IDLE ? (bus.instr_valid ? S_DECODE : S_IDLE)
                : in_dec ? (is_ld ? S_EXEC : is_halt ? S_HALT : S_IDLE)
                : state == S_EXEC ? S_IDLE
                : (bus.resume ? S_IDLE : S_HALT);
  // capture the instruction only when the handshake fires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      opnd_q <= '0;
    end else if (take) begin
      op_q <= bus.instr_opcode;
      opnd_q <= bus.instr_operand;
    end
  // registered load strobe, held load data and illegal pulse, all set up during DECODE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.load_en <= '0;
      bus.load_data <= '0;
      bus.illegal_op <= 1'b0;
    end else begin
      bus.load_en <= in_dec && is_ld ? NUM_REGS'(1) << (op_q - OPCODE_W'(1)) : '0;
      bus.load_data <= in_dec && is_ld ? opnd_q : bus.load_data;
      bus.illegal_op <= ill_inc;
    end
  sat_counter #(.W(CNT_W)) u_retired (.clk(clk), .rst_n(rst_n), .inc(ret_inc), .count(bus.retired_cnt));
  sat_counter #(.W(CNT_W)) u_illegal (.clk(clk), .rst_n(rst_n), .inc(ill_inc), .count(bus.illegal_cnt));
endmodule

// File: tb/tb_reg_load_sequencer.sv
// tb_reg_load_sequencer: directed checks of load, NOP, illegal, halt, reset and saturation behaviour
module tb_reg_load_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  reg_load_sequencer_if ia ();
  reg_load_sequencer_if #(.CNT_W(2)) ib ();
  reg_load_sequencer_if #(.NUM_REGS(14)) ic ();
  reg_load_sequencer u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  reg_load_sequencer #(.CNT_W(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  reg_load_sequencer #(.NUM_REGS(14)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    ia.instr_valid = 0; ia.instr_opcode = 0; ia.instr_operand = 0; ia.resume = 0;
    ib.instr_valid = 0; ib.instr_opcode = 0; ib.instr_operand = 0; ib.resume = 0;
    ic.instr_valid = 0; ic.instr_opcode = 0; ic.instr_operand = 0; ic.resume = 0;
    #12;
    chk("rst_ready", 32'(ia.instr_ready), 1);
    chk("rst_halted", 32'(ia.halted), 0);
    chk("rst_load_en", 32'(ia.load_en), 0);
    chk("rst_load_data", 32'(ia.load_data), 0);
    chk("rst_illegal_op", 32'(ia.illegal_op), 0);
    chk("rst_retired", 32'(ia.retired_cnt), 0);
    chk("rst_illegal", 32'(ia.illegal_cnt), 0);
    step();
    rst_n = 1;
    step();
    ia.instr_valid = 1; ia.instr_opcode = 2; ia.instr_operand = 8'hA5;
    step();
    chk("ld_dec_ready", 32'(ia.instr_ready), 0);
    chk("ld_dec_en", 32'(ia.load_en), 0);
    ia.instr_valid = 0; ia.instr_opcode = 3; ia.instr_operand = 8'hFF;
    step();
    chk("ld_exec_en", 32'(ia.load_en), 32'b010);
    chk("ld_exec_data", 32'(ia.load_data), 32'hA5);
    chk("ld_exec_ready", 32'(ia.instr_ready), 0);
    chk("ld_exec_ret", 32'(ia.retired_cnt), 0);
    step();
    chk("ld_done_ready", 32'(ia.instr_ready), 1);
    chk("ld_done_en", 32'(ia.load_en), 0);
    chk("ld_done_data", 32'(ia.load_data), 32'hA5);
    chk("ld_done_ret", 32'(ia.retired_cnt), 1);
    ia.instr_valid = 1; ia.instr_opcode = 1; ia.instr_operand = 8'h11;
    step();
    ia.instr_opcode = 3; ia.instr_operand = 8'h33;
    step();
    chk("b2b_en1", 32'(ia.load_en), 32'b001);
    chk("b2b_data1", 32'(ia.load_data), 32'h11);
    step();
    chk("b2b_idle_en", 32'(ia.load_en), 0);
    chk("b2b_idle_ready", 32'(ia.instr_ready), 1);
    chk("b2b_ret2", 32'(ia.retired_cnt), 2);
    step();
    chk("b2b_dec3_en", 32'(ia.load_en), 0);
    ia.instr_opcode = 0; ia.instr_operand = 8'h99;
    step();
    chk("b2b_en3", 32'(ia.load_en), 32'b100);
    chk("b2b_data3", 32'(ia.load_data), 32'h33);
    step();
    chk("b2b_ret3", 32'(ia.retired_cnt), 3);
    step();
    chk("nop_dec_en", 32'(ia.load_en), 0);
    ia.instr_valid = 0;
    step();
    chk("nop_en", 32'(ia.load_en), 0);
    chk("nop_data", 32'(ia.load_data), 32'h33);
    chk("nop_ret", 32'(ia.retired_cnt), 4);
    chk("nop_ready", 32'(ia.instr_ready), 1);
    ia.instr_valid = 1; ia.instr_opcode = 5; ia.instr_operand = 8'h55;
    step();
    ia.instr_valid = 0;
    chk("ill_dec_pulse", 32'(ia.illegal_op), 0);
    step();
    chk("ill_pulse", 32'(ia.illegal_op), 1);
    chk("ill_cnt", 32'(ia.illegal_cnt), 1);
    chk("ill_en", 32'(ia.load_en), 0);
    chk("ill_ret", 32'(ia.retired_cnt), 4);
    chk("ill_ready", 32'(ia.instr_ready), 1);
    step();
    chk("ill_pulse_end", 32'(ia.illegal_op), 0);
    chk("ill_en2", 32'(ia.load_en), 0);
    ia.instr_valid = 1; ia.instr_opcode = 4'hF; ia.instr_operand = 8'h00;
    step();
    ia.instr_opcode = 1; ia.instr_operand = 8'h5C; ia.resume = 1;
    step();
    ia.resume = 0;
    for (int i = 0; i < 10; i++) begin
      chk("halt_halted", 32'(ia.halted), 1);
      chk("halt_ready", 32'(ia.instr_ready), 0);
      step();
    end
    chk("halt_ret", 32'(ia.retired_cnt), 4);
    chk("halt_ill", 32'(ia.illegal_cnt), 1);
    chk("halt_en", 32'(ia.load_en), 0);
    ia.resume = 1;
    step();
    ia.resume = 0;
    chk("resume_halted", 32'(ia.halted), 0);
    chk("resume_ready", 32'(ia.instr_ready), 1);
    step();
    chk("pend_dec_ready", 32'(ia.instr_ready), 0);
    ia.instr_valid = 0;
    step();
    chk("pend_en", 32'(ia.load_en), 32'b001);
    chk("pend_data", 32'(ia.load_data), 32'h5C);
    step();
    chk("pend_ret", 32'(ia.retired_cnt), 5);
    ia.instr_valid = 1; ia.instr_opcode = 3; ia.instr_operand = 8'h77;
    step();
    ia.instr_valid = 0;
    step();
    chk("rx_exec_en", 32'(ia.load_en), 32'b100);
    #2 rst_n = 0;
    #1;
    chk("rx_en", 32'(ia.load_en), 0);
    chk("rx_ret", 32'(ia.retired_cnt), 0);
    chk("rx_ill", 32'(ia.illegal_cnt), 0);
    chk("rx_ready", 32'(ia.instr_ready), 1);
    step();
    rst_n = 1;
    step();
    chk("rx_rel_ready", 32'(ia.instr_ready), 1);
    chk("rx_rel_ret", 32'(ia.retired_cnt), 0);
    chk("rx_rel_en", 32'(ia.load_en), 0);
    for (int i = 0; i < 5; i++) begin
      ib.instr_valid = 1; ib.instr_opcode = 0;
      step();
      ib.instr_valid = 0;
      step();
      chk("sat_ret", 32'(ib.retired_cnt), i < 3 ? i + 1 : 3);
    end
    chk("sat_ill", 32'(ib.illegal_cnt), 0);
    ic.instr_valid = 1; ic.instr_opcode = 14; ic.instr_operand = 8'hE1;
    step();
    ic.instr_valid = 0;
    step();
    chk("wide_en", 32'(ic.load_en), 32'h2000);
    chk("wide_data", 32'(ic.load_data), 32'hE1);
    step();
    chk("wide_ret", 32'(ic.retired_cnt), 1);
    chk("wide_ill", 32'(ic.illegal_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
